// File: rtl/eq_band_mixer.sv
// eq_band_mixer: serial band accumulator for the equalizer datapath.
// Accepts NUM_BANDS signed Q1.15 band samples over a valid/ready handshake,
// sums them in a W+4-bit accumulator and presents one mixed W-bit sample per
// frame, held until the downstream consumer takes it.
// Optional feature: define EQ_MIX_SAT_EN to clamp the final sum to the W-bit
// range and report clamping on o_sat_flag; without it the sum wraps and
// o_sat_flag stays 0.
module eq_band_mixer #(
  parameter int W         = 16,
  parameter int NUM_BANDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic [3:0]   o_band_idx,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_sat_flag
);

  localparam int         AW       = W + 4;
  localparam logic [3:0] LAST_IDX = 4'(NUM_BANDS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_acc;
  logic [3:0]      r_band_idx;
  logic [W-1:0]    r_out_data;
  logic            r_sat;

  logic            w_xfer;
  logic            w_last;
  logic [AW-1:0]   w_sum;
  logic [W-1:0]    w_red;
  logic            w_red_sat;

  // Reduce the widened frame sum to W bits; result is {sat, data}.
`ifdef EQ_MIX_SAT_EN
  function automatic logic [W:0] reduce_sum(input logic [AW-1:0] s);
    logic [4:0] top;
    logic [W:0] res;
    top = s[AW-1:W-1];
    // The sum fits in W bits exactly when the five top bits agree.
    if ((top == 5'b00000) || (top == 5'b11111)) begin
      res = {1'b0, s[W-1:0]};
    end else if (s[AW-1] == 1'b0) begin
      res = {1'b1, 1'b0, {(W-1){1'b1}}};
    end else begin
      res = {1'b1, 1'b1, {(W-1){1'b0}}};
    end
    return res;
  endfunction
`else
  function automatic logic [W:0] reduce_sum(input logic [AW-1:0] s);
    return {1'b0, s[W-1:0]};
  endfunction
`endif

  assign w_xfer = i_in_valid & (r_state == ST_ACCUM);
  assign w_last = (r_band_idx == LAST_IDX);
  assign w_sum  = r_acc + {{4{i_in_data[W-1]}}, i_in_data};
  assign {w_red_sat, w_red} = reduce_sum(w_sum);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: leave ACCUM on the last band, leave HOLD on consume.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_xfer && w_last) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (i_out_ready) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        o_in_ready  = 1'b1;
        o_out_valid = 1'b0;
      end
      ST_HOLD: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b1;
      end
      default: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
      end
    endcase
  end

  // Accumulate accepted bands; on the last band register the reduced result
  // and clear the accumulator for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= {AW{1'b0}};
      r_band_idx <= 4'd0;
      r_out_data <= {W{1'b0}};
      r_sat      <= 1'b0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_acc      <= {AW{1'b0}};
        r_band_idx <= 4'd0;
        r_out_data <= w_red;
        r_sat      <= w_red_sat;
      end else begin
        r_acc      <= w_sum;
        r_band_idx <= r_band_idx + 4'd1;
      end
    end else begin
      r_acc      <= r_acc;
      r_band_idx <= r_band_idx;
    end
  end

  assign o_band_idx = r_band_idx;
  assign o_out_data = r_out_data;
  assign o_sat_flag = r_sat;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: directed frames from the test plan
// plus randomized traffic, all checked against a frame-level reference model.
module tb_eq_band_mixer;
  localparam int W  = 16;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [W-1:0]  i_in_data = 16'h0000;
  logic [3:0]    o_band_idx;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic [W-1:0]  o_out_data;
  logic          o_sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: running frame sum, bands received, pending result.
  int            m_acc  = 0;
  int            m_cnt  = 0;
  bit            m_hold = 1'b0;
  logic [15:0]   m_data = 16'h0000;
  logic          m_sat  = 1'b0;

  eq_band_mixer #(.W(W), .NUM_BANDS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_band_idx  (o_band_idx),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_sat_flag  (o_sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame result from the plain integer sum.
  function automatic logic [16:0] ref_reduce(input int s);
    logic [16:0] r;
`ifdef EQ_MIX_SAT_EN
    if (s > 32767)       r = {1'b1, 16'h7FFF};
    else if (s < -32768) r = {1'b1, 16'h8000};
    else                 r = {1'b0, s[15:0]};
`else
    r = {1'b0, s[15:0]};
`endif
    return r;
  endfunction

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_acc  = 0;
      m_cnt  = 0;
      m_hold = 1'b0;
    end else begin
      chk("m_band_idx", {28'd0, o_band_idx}, m_cnt);
      chk("m_in_ready", {31'd0, o_in_ready}, {31'd0, !m_hold});
      chk("m_out_valid", {31'd0, o_out_valid}, {31'd0, m_hold});
      if (m_hold) begin
        chk("m_out_data", {16'd0, o_out_data}, {16'd0, m_data});
        chk("m_sat_flag", {31'd0, o_sat_flag}, {31'd0, m_sat});
        if (i_out_ready) m_hold = 1'b0;
      end else if (i_in_valid) begin
        m_acc += int'($signed(i_in_data));
        m_cnt++;
        if (m_cnt == NB) begin
          {m_sat, m_data} = ref_reduce(m_acc);
          m_acc  = 0;
          m_cnt  = 0;
          m_hold = 1'b1;
        end
      end
    end
  end

  // Present one sample (optionally after a bubble) until it is accepted.
  task automatic send(input logic [15:0] d, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
      i_in_valid = 1'b0;
    end
    @(posedge clk); #1;
    i_in_valid = 1'b1;
    i_in_data  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose for %h", d);
    end
  endtask

  // Wait for the frame result and check it against hand-computed values.
  task automatic wait_out(input string nm, input logic [15:0] ed, input logic es);
    bit ok;
    int lat;
    ok  = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_out_valid) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid never rose", nm);
    end else begin
      chk({nm, "_latency"}, lat, 0);
      chk({nm, "_data"}, {16'd0, o_out_data}, {16'd0, ed});
      chk({nm, "_sat"}, {31'd0, o_sat_flag}, {31'd0, es});
      if (i_out_ready) begin
        @(negedge clk);
        chk({nm, "_one_cycle"}, {31'd0, o_out_valid}, 32'd0);
      end
    end
  endtask

  task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_band_idx", {28'd0, o_band_idx}, 32'd0);
    chk("rst_out_data", {16'd0, o_out_data}, 32'd0);
    chk("rst_sat", {31'd0, o_sat_flag}, 32'd0);
    rst = 1'b0;
    i_out_ready = 1'b1;

    // Basic sum
    frame4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    wait_out("basic", 16'h4000, 1'b0);

    // Overflow handling
`ifdef EQ_MIX_SAT_EN
    frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out("pos_ovf", 16'h7FFF, 1'b1);
    frame4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    wait_out("neg_ovf", 16'h8000, 1'b1);
`else
    frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out("pos_wrap", 16'hFFFC, 1'b0);
    frame4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    wait_out("neg_wrap", 16'h0000, 1'b0);
`endif
    frame4(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000);
    wait_out("no_mid_clamp", 16'hFFFE, 1'b0);

    // Backpressure with a pending sample
    i_out_ready = 1'b0;
    frame4(16'h0500, 16'h0500, 16'h0500, 16'h0500);
    @(posedge clk); #1;
    i_in_valid = 1'b1;
    i_in_data  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, o_out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, o_in_ready}, 32'd0);
      chk("bp_band_idx", {28'd0, o_band_idx}, 32'd0);
      chk("bp_out_data", {16'd0, o_out_data}, 32'h0000_1400);
    end
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept_ready", {31'd0, o_in_ready}, 32'd1);
    chk("bp_accept_idx", {28'd0, o_band_idx}, 32'd0);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    wait_out("bp_next", 16'h1237, 1'b0);

    // Bubbles between bands
    send(16'h0100, 1'b1);
    send(16'h0100, 1'b1);
    send(16'h0100, 1'b1);
    send(16'h0100, 1'b1);
    wait_out("bubble", 16'h0400, 1'b0);

    // Asynchronous reset mid-frame
    send(16'h2000, 1'b0);
    send(16'h2000, 1'b0);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("arst_band_idx", {28'd0, o_band_idx}, 32'd0);
    chk("arst_out_data", {16'd0, o_out_data}, 32'd0);
    chk("arst_sat", {31'd0, o_sat_flag}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    frame4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    wait_out("post_rst", 16'h0004, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      i_in_valid  = ($urandom_range(3, 0) != 0);
      i_out_ready = ($urandom_range(2, 0) != 0);
      case ($urandom_range(3, 0))
        0:       i_in_data = 16'h7FFF;
        1:       i_in_data = 16'h8000;
        2:       i_in_data = 16'($urandom_range(511, 0));
        default: i_in_data = 16'($urandom);
      endcase
    end

    @(posedge clk); #1;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
